instr_encoder: RTL and testbench
================================

# instr_encoder

Program-loader front end that runs the instruction path in reverse: it takes decoded instruction fields (format, opcode, registers, funct, immediate) over a valid/ready stream and packs them into 32-bit RV32I words. Each word is emitted with a sequential word address for writing into instruction memory. It sits between the testbench/boot source and the instruction-memory write port, and signals completion so the core can be released.

## Interface
- ADDR_WIDTH, 8, width of the emitted word address; the address wraps modulo 2^ADDR_WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session from IDLE or DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_fmt  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110 and 111 are illegal.
- in_op  in  7  opcode, placed in bits [6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  32  immediate, already at its architectural (byte-offset) value.
- in_last  in  1  marks the final bundle of the session.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_WIDTH  word address of out_instr.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- err  out  1  sticky illegal-input flag; see Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE or DONE, start=1: go to RUN, clear the address counter to 0, clear err.
- RUN, in_last accepted: go to DRAIN.
- DRAIN, output handshake completes: go to DONE.
- start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- On accept, the encoded word and the current address counter are registered to out_instr/out_addr. The counter then increments, wrapping from 2^ADDR_WIDTH−1 to 0.
- Packing (bit ranges of in_imm):
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - R: {funct7, rs2, rs1, funct3, rd, op}
- Fields that a format does not use are ignored.
- Illegal fmt encodes as 32'h0000_0013 (nop).

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err=0, address counter=0, state IDLE.
- Latency: exactly 1 cycle from input accept to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_instr and out_addr hold stable and in_ready=0.
- Simultaneous output handshake and new input accept: the register reloads and out_valid stays 1.
- Output handshake with no new accept: out_valid falls the next cycle.
- done rises the cycle after the last word's handshake and holds until start or rst.
- rst mid-session: the pending word is discarded immediately (asynchronous) and all outputs take their reset values.

## Configuration
- ENCODER_CHECK_EN defined: on accept, err is set (sticky until start/rst) if either:
  - fmt is 110 or 111; or
  - fmt is B or J with imm[0]=1.
- The offending word is still emitted, so addresses stay contiguous.
- ENCODER_CHECK_EN undefined: err is tied to 0 and there is no check logic.

## Test plan
- R-type: start, then fmt=101, op=0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0, last=1 → out_instr=0x002081B3 and out_addr=0 one cycle later; done high the cycle after the handshake.
- I/U stream: addi x1,x0,5 then lui x5,0x12345 (imm=0x12345000) back-to-back with out_ready=1 → 0x00500093 @0, then 0x123452B7 @1, on consecutive cycles.
- B/J packing: beq x1,x2 with imm=−8 → 0xFE208CE3; jal x1 with imm=2048 → 0x001000EF.
- Backpressure: hold out_ready=0 for 3 cycles with a word pending → out_instr/out_addr stable, in_ready=0; release → the next word follows; the last word passes through DRAIN → DONE.
- Wrap and reset: ADDR_WIDTH=2, five words → out_addr 0,1,2,3,0. Asserting rst mid-stream → out_valid=0, busy=0, state IDLE the same cycle.
- Check: fmt=010 with imm=3 → err=1 with ENCODER_CHECK_EN, err=0 without; the word is emitted in both builds.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of instr_encoder.
// The encoder takes the slave modport; the boot source / imem writer takes master.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_fmt;
  logic [6:0]            in_op;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into 32-bit words with sequential word addresses for imem loading.
// Optional ENCODER_CHECK_EN: sticky err on illegal format or odd B/J branch offset.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [2:0]            FMT_I    = 3'b000;
  localparam logic [2:0]            FMT_S    = 3'b001;
  localparam logic [2:0]            FMT_B    = 3'b010;
  localparam logic [2:0]            FMT_J    = 3'b011;
  localparam logic [2:0]            FMT_U    = 3'b100;
  localparam logic [2:0]            FMT_R    = 3'b101;
  localparam logic [31:0]           NOP      = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  accept, out_hs, sess_start;
  logic [31:0]           enc_word;

  assign bus.in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;
  assign sess_start   = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    case (bus.in_fmt)
      FMT_I: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
      FMT_S: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:0], bus.in_op};
      FMT_B: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                         bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_op};
      FMT_J: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                         bus.in_imm[19:12], bus.in_rd, bus.in_op};
      FMT_U: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_op};
      FMT_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_op};
      default: enc_word = NOP;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;

    // A handshake and a new accept in the same cycle leave out_valid high with the new word.
    if (out_hs) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_addr_d  = addr_q;
      addr_d      = addr_q + ADDR_ONE;
    end

    case (state_q)
      IDLE, DONE: if (sess_start) begin
        state_d = RUN;
        addr_d  = '0;
      end
      RUN:     if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   if (out_hs) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

`ifdef ENCODER_CHECK_EN
  logic err_q, err_d, illegal;

  // The offending word is still emitted so the address sequence stays contiguous.
  always_comb begin
    illegal = (bus.in_fmt[2:1] == 2'b11) ||
              (((bus.in_fmt == FMT_B) || (bus.in_fmt == FMT_J)) && bus.in_imm[0]);
    err_d   = err_q;
    if (sess_start)            err_d = 1'b0;
    else if (accept && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: known-answer table, hand sequences and a randomized
// stream scored against a transaction-level model of the loader.
module tb_instr_encoder;
  localparam int AW       = 2;
  localparam int ADDR_MOD = 1 << AW;
`ifdef ENCODER_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done, err;

  instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          phase;          // 0 idle, 1 loading, 2 draining, 3 finished
  int          next_addr;
  bit          err_m;
  bit          last_acc;
  bit          rand_ready;
  bit          rand_start;
  logic [31:0] cur_exp;
  logic [31:0] exp_q[$];
  int          exp_a[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Architectural packing: scatter immediate bits into their RV32I positions arithmetically.
  function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base_r, w;
    base_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt)
      3'd0: w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
              | (32'(rd) << 7) | 32'(op);
      3'd1: w = base_r | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      3'd2: w = base_r | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd3: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
              | (32'(rd) << 7) | 32'(op);
      3'd4: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      3'd5: w = base_r | (32'(f7) << 25) | (32'(rd) << 7);
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  task automatic offer(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input logic last);
    bus.in_fmt    = fmt;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_last   = last;
    cur_exp       = ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm);
  endtask

  task automatic model_reset();
    phase     = 0;
    next_addr = 0;
    err_m     = 1'b0;
    exp_q.delete();
    exp_a.delete();
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit exp_ready;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    if (rand_start) start = ($urandom_range(0, 7) == 0);
    @(negedge clk);
    exp_ready = (phase == 1) && (exp_q.size() == 0 || bus.out_ready);
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(phase == 1 || phase == 2));
    check("done", 32'(done), 32'(phase == 3));
    check("err", 32'(err), 32'(err_m));
    if (exp_q.size() != 0) begin
      check("out_instr", bus.out_instr, exp_q[0]);
      check("out_addr", 32'(bus.out_addr), 32'(exp_a[0]));
    end
    last_acc = bus.in_valid && exp_ready;
    if (exp_q.size() != 0 && bus.out_ready) begin
      void'(exp_q.pop_front());
      void'(exp_a.pop_front());
    end
    if (last_acc) begin
      exp_q.push_back(cur_exp);
      exp_a.push_back(next_addr);
      next_addr = (next_addr + 1) % ADDR_MOD;
      if (ERR_ON && (bus.in_fmt >= 3'd6 ||
          ((bus.in_fmt == 3'd2 || bus.in_fmt == 3'd3) && bus.in_imm[0]))) err_m = 1'b1;
      if (bus.in_last) phase = 2;
    end
    if (phase == 2 && exp_q.size() == 0) phase = 3;
    if (start && (phase == 0 || phase == 3)) begin
      phase     = 1;
      next_addr = 0;
      err_m     = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      cycle();
      ok = last_acc;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail_timeout("accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && phase != 3; i++) cycle();
    if (phase != 3) fail_timeout("drain");
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rand_ready = 1'b0; rand_start = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    offer(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    model_reset();

    vecs[0] = '{3'd5, 7'h33, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3};
    vecs[1] = '{3'd0, 7'h13, 5'd1,  5'd0, 5'd9,  3'd0, 7'h55, 32'h0000_0005, 32'h0050_0093};
    vecs[2] = '{3'd4, 7'h37, 5'd5,  5'd7, 5'd3,  3'd5, 7'h11, 32'h1234_5000, 32'h1234_52B7};
    vecs[3] = '{3'd2, 7'h63, 5'd9,  5'd1, 5'd2,  3'd0, 7'h7F, 32'hFFFF_FFF8, 32'hFE20_8CE3};
    vecs[4] = '{3'd3, 7'h6F, 5'd1,  5'd4, 5'd6,  3'd7, 7'h22, 32'h0000_0800, 32'h0010_00EF};
    vecs[5] = '{3'd1, 7'h23, 5'd31, 5'd1, 5'd2,  3'd2, 7'h3C, 32'h0000_0008, 32'h0020_A423};
    vecs[6] = '{3'd6, 7'h7F, 5'd17, 5'd8, 5'd12, 3'd3, 7'h19, 32'hDEAD_BEEF, 32'h0000_0013};
    vecs[7] = '{3'd7, 7'h01, 5'd2,  5'd3, 5'd4,  3'd1, 7'h40, 32'h0000_0001, 32'h0000_0013};

    // Reset values while rst is held.
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Single R-type session.
    start_session();
    offer(vecs[0].fmt, vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2,
          vecs[0].f3, vecs[0].f7, vecs[0].imm, 1'b1);
    cur_exp = vecs[0].exp;
    wait_accept();
    drain();

    // Back-to-back known-answer stream, restarted from DONE.
    start_session();
    for (int i = 1; i < 8; i++) begin
      offer(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].f3, vecs[i].f7, vecs[i].imm, i == 7);
      cur_exp = vecs[i].exp;
      wait_accept();
    end
    drain();

    // Backpressure: word pending for three stalled cycles, then released.
    start_session();
    bus.out_ready = 1'b0;
    offer(3'd0, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 1'b0);
    wait_accept();
    offer(3'd5, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0, 1'b1);
    bus.in_valid = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b1;
    wait_accept();
    drain();

    // Five words on a 2-bit address: 0,1,2,3,0.
    start_session();
    for (int i = 0; i < 5; i++) begin
      offer(3'd4, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12, i == 4);
      wait_accept();
    end
    drain();

    // Odd B-type offset: word still emitted, err only in the checking build.
    start_session();
    offer(3'd2, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd3, 1'b1);
    wait_accept();
    drain();
    check("err_b_odd", 32'(err), 32'(ERR_ON));

    // Randomized stream with gaps, random backpressure and ignored start pulses.
    start_session();
    rand_ready = 1'b1;
    rand_start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) cycle();
      offer(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom), 7'($urandom), $urandom, n == 299);
      wait_accept();
    end
    rand_start = 1'b0;
    start = 1'b0;
    drain();
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;

    // Asynchronous reset with a word pending.
    start_session();
    bus.out_ready = 1'b0;
    offer(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0010, 1'b0);
    wait_accept();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_out_instr", bus.out_instr, 32'd0);
    check("mid_rst_out_addr", 32'(bus.out_addr), 32'd0);
    model_reset();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Fresh session after reset starts again at address 0.
    start_session();
    offer(3'd0, 7'h13, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 1'b1);
    wait_accept();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
